// File: rtl/typing_wpm_calc.sv
// Typing-test scorer: counts correct keystrokes, then computes WPM = chars*120/deciseconds
// with a sequential restoring divider. Optional macro WPM_BCD_EN adds a double-dabble wpm_bcd output.
module typing_wpm_calc #(
  parameter int CNT_W = 10,
  parameter int WPM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_valid,
  input  logic             key_correct,
  input  logic             finish,
  input  logic             at_end,
  input  logic [3:0]       deciseconds_in,
  input  logic [3:0]       seconds_in,
  input  logic [3:0]       decaseconds_in,
  input  logic             clear,
  output logic [CNT_W-1:0] char_count,
  output logic             busy,
  output logic [WPM_W-1:0] wpm,
`ifdef WPM_BCD_EN
  output logic [11:0]      wpm_bcd,
`endif
  output logic             wpm_valid
);

  localparam int NUM_W    = CNT_W + 7;
  localparam int STEP_MAX = (NUM_W > WPM_W) ? NUM_W : WPM_W;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam logic [STEP_W-1:0] DIV_STEPS = STEP_W'(NUM_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, COUNT, LOAD, DIV, CONV, DONE} state_t;

  state_t            state;
  logic              at_end_prev;
  logic [STEP_W-1:0] step;

  logic [9:0]        divisor;
  logic [NUM_W-1:0]  dividend;
  logic [9:0]        remainder;
  logic [NUM_W-1:0]  quotient;
  logic [10:0]       rem_shift;
  logic              rem_ge;
  logic [9:0]        rem_next;
  logic [WPM_W-1:0]  wpm_result;

  function automatic logic [9:0] bcd_to_ds(input logic [3:0] dec, input logic [3:0] sec,
                                           input logic [3:0] deci);
    return 10'(14'(dec) * 14'd100 + 14'(sec) * 14'd10 + 14'(deci));
  endfunction

  function automatic logic [WPM_W-1:0] sat_wpm(input logic [NUM_W-1:0] q, input logic div_zero);
    if (div_zero) return '0;
    if ((q >> WPM_W) != '0) return '1;
    return q[WPM_W-1:0];
  endfunction

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift  = {remainder, dividend[NUM_W-1]};
    rem_ge     = (rem_shift >= {1'b0, divisor});
    rem_next   = rem_ge ? 10'(rem_shift - {1'b0, divisor}) : rem_shift[9:0];
    wpm_result = sat_wpm(quotient, divisor == 10'd0);
  end

`ifdef WPM_BCD_EN
  localparam logic [STEP_W-1:0] CONV_LAST = STEP_W'(WPM_W - 1);

  logic [WPM_W-1:0] bin_sh;
  logic [15:0]      bcd_sh;
  logic [15:0]      dd_adj;
  logic [16:0]      bcd_final;

  always_comb begin
    dd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      dd_adj[4*i +: 4] = (bcd_sh[4*i +: 4] >= 4'd5) ? bcd_sh[4*i +: 4] + 4'd3 : bcd_sh[4*i +: 4];
    end
    bcd_final = {dd_adj, bin_sh[WPM_W-1]};
  end
`endif

  // Datapath registers: only meaningful while the FSM is in LOAD/DIV/CONV.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      divisor   <= bcd_to_ds(decaseconds_in, seconds_in, deciseconds_in);
      dividend  <= NUM_W'(char_count) * NUM_W'(120);
      remainder <= '0;
      quotient  <= '0;
    end else if (state == DIV && step < DIV_STEPS) begin
      dividend  <= dividend << 1;
      remainder <= rem_next;
      quotient  <= {quotient[NUM_W-2:0], rem_ge};
    end
`ifdef WPM_BCD_EN
    if (state == DIV && step == DIV_STEPS) begin
      bin_sh <= wpm_result;
      bcd_sh <= '0;
    end else if (state == CONV) begin
      bin_sh <= bin_sh << 1;
      bcd_sh <= bcd_final[15:0];
    end
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      at_end_prev <= 1'b0;
      step        <= '0;
      char_count  <= '0;
      busy        <= 1'b0;
      wpm         <= '0;
      wpm_valid   <= 1'b0;
`ifdef WPM_BCD_EN
      wpm_bcd     <= '0;
`endif
    end else begin
      at_end_prev <= at_end;
      if (clear) begin
        state      <= IDLE;
        step       <= '0;
        char_count <= '0;
        busy       <= 1'b0;
        wpm        <= '0;
        wpm_valid  <= 1'b0;
`ifdef WPM_BCD_EN
        wpm_bcd    <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            char_count <= '0;
            if (start) state <= COUNT;
          end
          COUNT: begin
            if (key_valid && key_correct && start && char_count != CNT_MAX)
              char_count <= char_count + 1'b1;
            if (finish || (at_end && !at_end_prev)) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            step  <= '0;
            state <= DIV;
          end
          DIV: begin
            if (step < DIV_STEPS) begin
              step <= step + 1'b1;
            end else begin
              step <= '0;
              wpm  <= wpm_result;
`ifdef WPM_BCD_EN
              state <= CONV;
`else
              state     <= DONE;
              busy      <= 1'b0;
              wpm_valid <= 1'b1;
`endif
            end
          end
`ifdef WPM_BCD_EN
          CONV: begin
            if (step == CONV_LAST) begin
              step      <= '0;
              state     <= DONE;
              busy      <= 1'b0;
              wpm_valid <= 1'b1;
              wpm_bcd   <= (bcd_final[16:12] != 5'd0) ? 12'h999 : bcd_final[11:0];
            end else begin
              step <= step + 1'b1;
            end
          end
`endif
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_typing_wpm_calc.sv
// Self-checking bench for typing_wpm_calc; randomized scenarios compared against an arithmetic model.
// Honours WPM_BCD_EN when the design is built with it.
`timescale 1ns/1ps
module tb_typing_wpm_calc;
  localparam int CNT_W = 10;
  localparam int WPM_W = 10;
  localparam int NUM_W = CNT_W + 7;
`ifdef WPM_BCD_EN
  localparam int LAT = NUM_W + WPM_W + 2;
`else
  localparam int LAT = NUM_W + 2;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, key_valid = 1'b0, key_correct = 1'b0;
  logic finish = 1'b0, at_end = 1'b0, clear = 1'b0;
  logic [3:0] deciseconds_in = '0, seconds_in = '0, decaseconds_in = '0;
  logic [CNT_W-1:0] char_count;
  logic             busy;
  logic [WPM_W-1:0] wpm;
  logic             wpm_valid;
`ifdef WPM_BCD_EN
  logic [11:0]      wpm_bcd;
`endif

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  typing_wpm_calc #(.CNT_W(CNT_W), .WPM_W(WPM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_correct(key_correct),
    .finish(finish), .at_end(at_end), .deciseconds_in(deciseconds_in), .seconds_in(seconds_in),
    .decaseconds_in(decaseconds_in), .clear(clear), .char_count(char_count), .busy(busy),
    .wpm(wpm),
`ifdef WPM_BCD_EN
    .wpm_bcd(wpm_bcd),
`endif
    .wpm_valid(wpm_valid)
  );

  // Reference model: elapsed time in deciseconds and the resulting score.
  function automatic int ref_ds(input int dec, input int sec, input int deci);
    return (dec * 100 + sec * 10 + deci) % 1024;
  endfunction

  function automatic int ref_wpm(input int chars, input int ds);
    int v;
    if (ds == 0) return 0;
    v = (chars * 120) / ds;
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    if (v > 999) return 12'h999;
    r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; start = 1'b0; key_valid = 1'b0; key_correct = 1'b0;
    finish = 1'b0; at_end = 1'b0; clear = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic keys(input int n, input logic correct);
    key_valid = 1'b1; key_correct = correct;
    repeat (n) tick;
    key_valid = 1'b0; key_correct = 1'b0;
  endtask

  // Fire a trigger and count edges until wpm_valid; -1 means it never came.
  task automatic fire(input logic use_finish, input int dec, input int sec, input int deci,
                      output int lat);
    decaseconds_in = 4'(dec); seconds_in = 4'(sec); deciseconds_in = 4'(deci);
    if (use_finish) finish = 1'b1;
    else at_end = 1'b1;
    tick;
    finish = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      if (wpm_valid === 1'b1) begin
        lat = k;
        break;
      end
      tick;
    end
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0; at_end = 1'b0; key_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    asserts++; if (char_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", char_count); end
    asserts++; if (wpm !== '0) begin failures++; $display("FAIL reset_wpm: got %0d want 0", wpm); end
    asserts++; if (wpm_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", wpm_valid); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef WPM_BCD_EN
    asserts++; if (wpm_bcd !== '0) begin failures++; $display("FAIL reset_bcd: got %h want 0", wpm_bcd); end
`endif
    start = 1'b1; tick;
    keys(7, 1'b1);
    asserts++; if (char_count !== 10'd7) begin failures++; $display("FAIL pre_reset_count: got %0d want 7", char_count); end
    rst = 1'b0;
    #1;
    asserts++; if (char_count !== '0) begin failures++; $display("FAIL async_count: got %0d want 0", char_count); end
    asserts++; if (wpm !== '0 || wpm_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL async_outputs: got wpm=%0d valid=%b busy=%b want 0/0/0", wpm, wpm_valid, busy);
    end
    rst = 1'b1; start = 1'b0;
    tick;
  endtask

  task automatic test_at_end;
    int lat, exp;
    do_reset;
    at_end = 1'b1;
    start = 1'b1; tick;
    keys(50, 1'b1);
    tick; tick;
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL at_end_level_no_trigger: got busy=%b want 0", busy); end
    at_end = 1'b0; tick;
    fire(1'b0, 6, 0, 0, lat);
    exp = ref_wpm(50, ref_ds(6, 0, 0));
    asserts++; if (lat != LAT) begin failures++; $display("FAIL at_end_latency: got %0d want %0d", lat, LAT); end
    asserts++; if (wpm !== WPM_W'(exp)) begin failures++; $display("FAIL at_end_wpm: got %0d want %0d", wpm, exp); end
    asserts++; if (char_count !== 10'd50) begin failures++; $display("FAIL at_end_count: got %0d want 50", char_count); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy: got %b want 0", busy); end
    do_clear;
    asserts++; if (wpm !== '0 || wpm_valid !== 1'b0 || char_count !== '0) begin
      failures++; $display("FAIL clear_outputs: got wpm=%0d valid=%b count=%0d want 0/0/0", wpm, wpm_valid, char_count);
    end
`ifdef WPM_BCD_EN
    asserts++; if (wpm_bcd !== '0) begin failures++; $display("FAIL clear_bcd: got %h want 0", wpm_bcd); end
`endif
  endtask

  task automatic test_mixed_keys;
    int lat;
    do_reset;
    start = 1'b1; tick;
    keys(125, 1'b1); keys(30, 1'b0); keys(125, 1'b1);
    fire(1'b1, 3, 0, 0, lat);
    asserts++; if (char_count !== 10'd250) begin failures++; $display("FAIL mixed_count: got %0d want 250", char_count); end
    asserts++; if (wpm !== 10'd100) begin failures++; $display("FAIL mixed_wpm: got %0d want 100", wpm); end
    asserts++; if (lat != LAT) begin failures++; $display("FAIL mixed_latency: got %0d want %0d", lat, LAT); end
`ifdef WPM_BCD_EN
    asserts++; if (wpm_bcd !== 12'h100) begin failures++; $display("FAIL mixed_bcd: got %h want 100", wpm_bcd); end
`endif
    keys(5, 1'b1);
    finish = 1'b1; tick; finish = 1'b0;
    at_end = 1'b1; tick; at_end = 1'b0; tick; at_end = 1'b1; tick;
    asserts++; if (wpm !== 10'd100 || wpm_valid !== 1'b1 || char_count !== 10'd250) begin
      failures++; $display("FAIL done_hold: got wpm=%0d valid=%b count=%0d want 100/1/250", wpm, wpm_valid, char_count);
    end
    do_clear;
  endtask

  task automatic test_paused_keys;
    int lat;
    do_reset;
    start = 1'b1; tick;
    start = 1'b0; keys(20, 1'b1);
    start = 1'b1; keys(5, 1'b1);
    fire(1'b1, 0, 0, 0, lat);
    asserts++; if (char_count !== 10'd5) begin failures++; $display("FAIL paused_count: got %0d want 5", char_count); end
    asserts++; if (wpm !== '0) begin failures++; $display("FAIL zero_time_wpm: got %0d want 0", wpm); end
    asserts++; if (lat != LAT) begin failures++; $display("FAIL zero_time_latency: got %0d want %0d", lat, LAT); end
    do_clear;
  endtask

  task automatic test_saturation;
    int lat;
    do_reset;
    start = 1'b1; tick;
    keys(1023, 1'b1);
    asserts++; if (char_count !== 10'd1023) begin failures++; $display("FAIL sat_count: got %0d want 1023", char_count); end
    keys(10, 1'b1);
    asserts++; if (char_count !== 10'd1023) begin failures++; $display("FAIL sat_hold: got %0d want 1023", char_count); end
    fire(1'b1, 0, 0, 1, lat);
    asserts++; if (wpm !== 10'd1023) begin failures++; $display("FAIL sat_wpm: got %0d want 1023", wpm); end
    asserts++; if (lat != LAT) begin failures++; $display("FAIL sat_latency: got %0d want %0d", lat, LAT); end
`ifdef WPM_BCD_EN
    asserts++; if (wpm_bcd !== 12'h999) begin failures++; $display("FAIL sat_bcd: got %h want 999", wpm_bcd); end
`endif
    do_clear;
  endtask

  task automatic test_clear_mid_div;
    logic saw_valid;
    do_reset;
    start = 1'b1; tick;
    keys(40, 1'b1);
    finish = 1'b1; tick; finish = 1'b0;
    tick;
    repeat (5) tick;
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL div_busy: got %b want 1", busy); end
    clear = 1'b1; tick; clear = 1'b0;
    asserts++; if (busy !== 1'b0 || char_count !== '0 || wpm_valid !== 1'b0) begin
      failures++; $display("FAIL clear_abort: got busy=%b count=%0d valid=%b want 0/0/0", busy, char_count, wpm_valid);
    end
    saw_valid = 1'b0;
    repeat (40) begin
      tick;
      if (wpm_valid === 1'b1) saw_valid = 1'b1;
    end
    asserts++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", saw_valid); end
    keys(3, 1'b1);
    asserts++; if (char_count !== 10'd3) begin failures++; $display("FAIL recount: got %0d want 3", char_count); end
    do_clear;
  endtask

  task automatic test_random;
    int model, n, lat, dec, sec, deci, exp;
    logic use_finish;
    for (int it = 0; it < 8; it++) begin
      do_reset;
      start = 1'b1; tick;
      model = 0;
      n = $urandom_range(400, 50);
      for (int c = 0; c < n; c++) begin
        key_valid = 1'($urandom % 2);
        key_correct = (($urandom % 4) != 0);
        start = (($urandom % 5) != 0);
        if (key_valid && key_correct && start && model < 1023) model++;
        tick;
      end
      start = 1'b1;
      key_valid = 1'($urandom % 2); key_correct = 1'b1;
      if (key_valid && model < 1023) model++;
      dec = $urandom_range(15, 0); sec = $urandom_range(9, 0); deci = $urandom_range(9, 0);
      use_finish = 1'($urandom % 2);
      fire(use_finish, dec, sec, deci, lat);
      key_valid = 1'b0;
      exp = ref_wpm(model, ref_ds(dec, sec, deci));
      asserts++; if (char_count !== CNT_W'(model)) begin failures++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, char_count, model); end
      asserts++; if (wpm !== WPM_W'(exp)) begin failures++; $display("FAIL rand_wpm[%0d]: got %0d want %0d", it, wpm, exp); end
      asserts++; if (lat != LAT) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, LAT); end
`ifdef WPM_BCD_EN
      asserts++; if (wpm_bcd !== ref_bcd(exp)) begin failures++; $display("FAIL rand_bcd[%0d]: got %h want %h", it, wpm_bcd, ref_bcd(exp)); end
`endif
      do_clear;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_at_end;
    test_mixed_keys;
    test_paused_keys;
    test_saturation;
    test_clear_mid_div;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
